eth_avst_rx_framer: RTL and testbench

ETH_AVST_RX_FRAMER -- requirements
Module: eth_avst_rx_framer

---
 rtl/eth_avst_rx_framer.sv | 205 ++++++++++++++++++++
 tb/tb_eth_avst_rx_framer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/eth_avst_rx_framer.sv
`default_nettype none
// ============================================================================
//  Module   : eth_avst_rx_framer
//  Purpose  : Converts a MAC-side Avalon-ST receive stream (no backpressure)
//             into a single-region MFB stream with one output register.
//             Words that cannot be accepted are dropped and counted. A packet
//             cut short after its SOF has gone out is closed with a synthetic
//             error EOF word.
//  Revision : 1.0  initial release
// ============================================================================
module eth_avst_rx_framer #(
  parameter int DATA_WIDTH  = 512,
  parameter int EMPTY_WIDTH = 6,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                   CLK,
  input  logic                   RESET_N,
  input  logic [DATA_WIDTH-1:0]  RX_AVST_DATA,
  input  logic                   RX_AVST_SOP,
  input  logic                   RX_AVST_EOP,
  input  logic [EMPTY_WIDTH-1:0] RX_AVST_EMPTY,
  input  logic                   RX_AVST_ERROR,
  input  logic                   RX_AVST_VALID,
  output logic [DATA_WIDTH-1:0]  TX_MFB_DATA,
  output logic                   TX_MFB_SOF,
  output logic                   TX_MFB_EOF,
  output logic [EMPTY_WIDTH-1:0] TX_MFB_EOF_POS,
  output logic                   TX_MFB_ERROR,
  output logic                   TX_MFB_SRC_RDY,
  input  logic                   TX_MFB_DST_RDY,
  output logic [CNT_WIDTH-1:0]   STAT_DISCARDED,
  output logic [CNT_WIDTH-1:0]   STAT_TRUNCATED
);

  // Position of the last byte in a full word.
  localparam logic [EMPTY_WIDTH-1:0] c_LAST_POS = EMPTY_WIDTH'(DATA_WIDTH/8 - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PKT     = 2'd1,
    ST_DISCARD = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic                   r_trunc_pending;
  logic                   r_out_open;

  logic [DATA_WIDTH-1:0]  r_data;
  logic                   r_sof;
  logic                   r_eof;
  logic [EMPTY_WIDTH-1:0] r_eof_pos;
  logic                   r_error;
  logic                   r_src_rdy;
  logic [CNT_WIDTH-1:0]   r_stat_disc;
  logic [CNT_WIDTH-1:0]   r_stat_trunc;

  logic                   w_free;
  logic                   w_want_fwd;
  logic                   w_fwd;
  logic                   w_drop;
  logic                   w_set_trunc;
  logic                   w_load_synth;

  // Output register can take a new word when empty or being drained now.
  assign w_free       = !r_src_rdy || TX_MFB_DST_RDY;
  // A pending truncation owns the register before any input word.
  assign w_load_synth = r_trunc_pending && w_free;
  assign w_fwd        = w_want_fwd && w_free;

  // Next-state decode: classify each valid word as forward or drop.
  always_comb begin
    w_state_nxt = r_state;
    w_want_fwd  = 1'b0;
    w_drop      = 1'b0;
    w_set_trunc = 1'b0;
    if (RX_AVST_VALID) begin
      if (r_trunc_pending) begin
        // Rest of the broken packet is discarded until its EOP.
        w_drop      = 1'b1;
        w_state_nxt = RX_AVST_EOP ? ST_IDLE : ST_DISCARD;
      end else begin
        unique case (r_state)
          ST_IDLE: begin
            if (RX_AVST_SOP) begin
              w_want_fwd  = 1'b1;
              w_state_nxt = RX_AVST_EOP ? ST_IDLE : ST_PKT;
            end else begin
              w_drop      = 1'b1;
              w_state_nxt = RX_AVST_EOP ? ST_IDLE : ST_DISCARD;
            end
          end
          ST_PKT: begin
            if (RX_AVST_SOP) begin
              // New SOP inside an open packet: close the old one with error.
              w_drop      = 1'b1;
              w_set_trunc = r_out_open;
              w_state_nxt = RX_AVST_EOP ? ST_IDLE : ST_DISCARD;
            end else begin
              w_want_fwd  = 1'b1;
              w_state_nxt = RX_AVST_EOP ? ST_IDLE : ST_PKT;
            end
          end
          ST_DISCARD: begin
            w_drop = 1'b1;
            if (RX_AVST_EOP) begin
              w_state_nxt = ST_IDLE;
            end
          end
          default: begin
            w_state_nxt = ST_IDLE;
          end
        endcase
        // Overflow: register busy, the word is lost. Only a mid-packet word
        // leaves an already-emitted SOF dangling.
        if (w_want_fwd && !w_free) begin
          w_drop      = 1'b1;
          w_set_trunc = !RX_AVST_SOP && r_out_open;
          w_state_nxt = RX_AVST_EOP ? ST_IDLE : ST_DISCARD;
        end
      end
    end
  end

  // Framing state, truncation request and open-packet tracking.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state         <= ST_IDLE;
      r_trunc_pending <= 1'b0;
      r_out_open      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load_synth) begin
        r_trunc_pending <= 1'b0;
      end else if (w_set_trunc) begin
        r_trunc_pending <= 1'b1;
      end
      if (w_load_synth) begin
        r_out_open <= 1'b0;
      end else if (w_fwd) begin
        if (RX_AVST_EOP) begin
          r_out_open <= 1'b0;
        end else if (RX_AVST_SOP) begin
          r_out_open <= 1'b1;
        end
      end
    end
  end

  // Output register: synthetic EOF first, then forwarded word, else drain.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_data    <= '0;
      r_sof     <= 1'b0;
      r_eof     <= 1'b0;
      r_eof_pos <= '0;
      r_error   <= 1'b0;
      r_src_rdy <= 1'b0;
    end else if (w_free) begin
      if (w_load_synth) begin
        r_data    <= '0;
        r_sof     <= 1'b0;
        r_eof     <= 1'b1;
        r_eof_pos <= c_LAST_POS;
        r_error   <= 1'b1;
        r_src_rdy <= 1'b1;
      end else if (w_fwd) begin
        r_data    <= RX_AVST_DATA;
        r_sof     <= RX_AVST_SOP;
        r_eof     <= RX_AVST_EOP;
        r_eof_pos <= RX_AVST_EOP ? (c_LAST_POS - RX_AVST_EMPTY) : '0;
        r_error   <= RX_AVST_EOP ? RX_AVST_ERROR : 1'b0;
        r_src_rdy <= 1'b1;
      end else begin
        r_src_rdy <= 1'b0;
      end
    end
  end

  // Statistics counters, free-running and wrapping.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_stat_disc  <= '0;
      r_stat_trunc <= '0;
    end else begin
      if (w_drop) begin
        r_stat_disc <= r_stat_disc + CNT_WIDTH'(1);
      end
      if (w_load_synth) begin
        r_stat_trunc <= r_stat_trunc + CNT_WIDTH'(1);
      end
    end
  end

  assign TX_MFB_DATA    = r_data;
  assign TX_MFB_SOF     = r_sof;
  assign TX_MFB_EOF     = r_eof;
  assign TX_MFB_EOF_POS = r_eof_pos;
  assign TX_MFB_ERROR   = r_error;
  assign TX_MFB_SRC_RDY = r_src_rdy;
  assign STAT_DISCARDED = r_stat_disc;
  assign STAT_TRUNCATED = r_stat_trunc;

endmodule
`default_nettype wire

// File: tb/tb_eth_avst_rx_framer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_eth_avst_rx_framer
//  Purpose  : Directed self-checking bench for eth_avst_rx_framer.
//  Revision : 1.0  initial release
// ============================================================================
module tb_eth_avst_rx_framer;

  localparam int DW = 512;
  localparam int EW = 6;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] i_data = '0;
  logic          i_sop = 1'b0;
  logic          i_eop = 1'b0;
  logic [EW-1:0] i_empty = '0;
  logic          i_err = 1'b0;
  logic          i_valid = 1'b0;
  logic          i_dst_rdy = 1'b1;
  logic [DW-1:0] o_data;
  logic          o_sof;
  logic          o_eof;
  logic [EW-1:0] o_eof_pos;
  logic          o_err;
  logic          o_src_rdy;
  logic [CW-1:0] o_disc;
  logic [CW-1:0] o_trunc;

  int total = 0;
  int bad   = 0;

  eth_avst_rx_framer #(.DATA_WIDTH(DW), .EMPTY_WIDTH(EW), .CNT_WIDTH(CW)) dut (
    .CLK            (clk),
    .RESET_N        (rst_n),
    .RX_AVST_DATA   (i_data),
    .RX_AVST_SOP    (i_sop),
    .RX_AVST_EOP    (i_eop),
    .RX_AVST_EMPTY  (i_empty),
    .RX_AVST_ERROR  (i_err),
    .RX_AVST_VALID  (i_valid),
    .TX_MFB_DATA    (o_data),
    .TX_MFB_SOF     (o_sof),
    .TX_MFB_EOF     (o_eof),
    .TX_MFB_EOF_POS (o_eof_pos),
    .TX_MFB_ERROR   (o_err),
    .TX_MFB_SRC_RDY (o_src_rdy),
    .TX_MFB_DST_RDY (i_dst_rdy),
    .STAT_DISCARDED (o_disc),
    .STAT_TRUNCATED (o_trunc)
  );

  always #5 clk = ~clk;

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic s, input logic e,
                       input logic [EW-1:0] emp, input logic er, input logic [DW-1:0] d);
    i_valid = v; i_sop = s; i_eop = e; i_empty = emp; i_err = er; i_data = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks the whole registered output word.
  task automatic chk_out(input string tag, input logic rdy, input logic sof, input logic eof,
                         input logic [EW-1:0] pos, input logic err, input logic [DW-1:0] d);
    chk({tag, ".rdy"}, DW'(o_src_rdy), DW'(rdy));
    chk({tag, ".sof"}, DW'(o_sof), DW'(sof));
    chk({tag, ".eof"}, DW'(o_eof), DW'(eof));
    chk({tag, ".pos"}, DW'(o_eof_pos), DW'(pos));
    chk({tag, ".err"}, DW'(o_err), DW'(err));
    chk({tag, ".data"}, o_data, d);
  endtask

  logic [DW-1:0] w1, w2, w3, w4;

  initial begin
    w1 = {16{32'h1111_0001}};
    w2 = {16{32'h2222_0002}};
    w3 = {16{32'h3333_0003}};
    w4 = {16{32'h4444_0004}};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk_out("reset", 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, '0);
    chk("reset.disc", DW'(o_disc), DW'(0));
    chk("reset.trunc", DW'(o_trunc), DW'(0));
    rst_n = 1'b1;

    // 3-word packet, EMPTY=4 -> EOF_POS=59
    drive(1, 1, 0, 6'd0, 0, w1); tick();
    chk_out("p3.w1", 1, 1, 0, 6'd0, 0, w1);
    drive(1, 0, 0, 6'd0, 0, w2); tick();
    chk_out("p3.w2", 1, 0, 0, 6'd0, 0, w2);
    drive(1, 0, 1, 6'd4, 0, w3); tick();
    chk_out("p3.w3", 1, 0, 1, 6'd59, 0, w3);
    drive(0, 0, 0, 6'd0, 0, '0); tick();
    chk("p3.idle.rdy", DW'(o_src_rdy), DW'(0));
    chk("p3.disc", DW'(o_disc), DW'(0));
    chk("p3.trunc", DW'(o_trunc), DW'(0));

    // Single-word packet with MAC error, EMPTY=0 -> EOF_POS=63
    drive(1, 1, 1, 6'd0, 1, w4); tick();
    chk_out("p1", 1, 1, 1, 6'd63, 1, w4);
    drive(0, 0, 0, 6'd0, 0, '0); tick();
    chk("p1.idle.rdy", DW'(o_src_rdy), DW'(0));

    // Backpressure overflow: SOF held, three words lost, synthetic EOF later
    drive(1, 1, 0, 6'd0, 0, w1); tick();
    chk_out("ovf.w1", 1, 1, 0, 6'd0, 0, w1);
    i_dst_rdy = 1'b0;
    drive(1, 0, 0, 6'd0, 0, w2); tick();
    chk_out("ovf.hold2", 1, 1, 0, 6'd0, 0, w1);
    drive(1, 0, 0, 6'd0, 0, w3); tick();
    drive(1, 0, 1, 6'd7, 0, w4); tick();
    chk_out("ovf.hold4", 1, 1, 0, 6'd0, 0, w1);
    chk("ovf.disc", DW'(o_disc), DW'(3));
    chk("ovf.trunc0", DW'(o_trunc), DW'(0));
    drive(0, 0, 0, 6'd0, 0, '0); tick();
    i_dst_rdy = 1'b1;
    tick();
    chk_out("ovf.synth", 1, 0, 1, 6'd63, 1, '0);
    chk("ovf.trunc", DW'(o_trunc), DW'(1));
    tick();
    chk("ovf.drain", DW'(o_src_rdy), DW'(0));

    // Malformed: SOP inside open packet, then clean packet
    drive(1, 1, 0, 6'd0, 0, w1); tick();
    chk_out("mal.p1", 1, 1, 0, 6'd0, 0, w1);
    drive(1, 0, 0, 6'd0, 0, w2); tick();
    chk_out("mal.p2", 1, 0, 0, 6'd0, 0, w2);
    drive(1, 1, 0, 6'd0, 0, w3); tick();
    chk("mal.sop.rdy", DW'(o_src_rdy), DW'(0));
    drive(1, 0, 0, 6'd0, 0, w4); tick();
    chk_out("mal.synth", 1, 0, 1, 6'd63, 1, '0);
    chk("mal.trunc", DW'(o_trunc), DW'(2));
    drive(1, 0, 1, 6'd0, 0, w1); tick();
    chk("mal.eop.rdy", DW'(o_src_rdy), DW'(0));
    chk("mal.disc", DW'(o_disc), DW'(6));
    drive(1, 1, 0, 6'd0, 0, w2); tick();
    chk_out("mal.q1", 1, 1, 0, 6'd0, 0, w2);
    drive(1, 0, 1, 6'd10, 0, w3); tick();
    chk_out("mal.q2", 1, 0, 1, 6'd53, 0, w3);

    // Words without SOP in IDLE are dropped
    drive(1, 0, 0, 6'd0, 0, w4); tick();
    chk("nosop.a.rdy", DW'(o_src_rdy), DW'(0));
    drive(1, 0, 1, 6'd0, 0, w1); tick();
    chk("nosop.b.rdy", DW'(o_src_rdy), DW'(0));
    chk("nosop.disc", DW'(o_disc), DW'(8));
    chk("nosop.trunc", DW'(o_trunc), DW'(2));
    drive(0, 0, 0, 6'd0, 0, '0); tick();

    // Asynchronous reset mid-packet
    drive(1, 1, 0, 6'd0, 0, w1); tick();
    chk("rst.pre.rdy", DW'(o_src_rdy), DW'(1));
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("rst.async", 0, 0, 0, 6'd0, 0, '0);
    chk("rst.disc", DW'(o_disc), DW'(0));
    chk("rst.trunc", DW'(o_trunc), DW'(0));
    #1;
    rst_n = 1'b1;
    drive(1, 0, 0, 6'd0, 0, w2); tick();
    chk("rst.tail1.rdy", DW'(o_src_rdy), DW'(0));
    drive(1, 0, 1, 6'd0, 0, w3); tick();
    chk("rst.tail2.rdy", DW'(o_src_rdy), DW'(0));
    chk("rst.tail.disc", DW'(o_disc), DW'(2));
    drive(1, 1, 1, 6'd2, 0, w4); tick();
    chk_out("rst.next", 1, 1, 1, 6'd61, 0, w4);
    drive(0, 0, 0, 6'd0, 0, '0); tick();
    chk("rst.end.rdy", DW'(o_src_rdy), DW'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
